// File: rtl/module_spi_master.sv
// Byte-wide SPI master shift engine, mode 0, MSB first, with a post-transfer hold window.
// Build option: define SPI_LOOPBACK_EN to shift mosi_o back in internally instead of miso_i.
module module_spi_master #(
    parameter int unsigned DIV      = 5,
    parameter int unsigned HOLD_CYC = 4
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       en_i,
    input  logic [7:0] data_tx_i,
    input  logic       miso_i,
    output logic [7:0] data_rx_o,
    output logic       fin_o,
    output logic       busy_o,
    output logic       sclk_o,
    output logic       mosi_o,
    output logic       cs_o
);

    localparam int unsigned DIV_W  = $clog2(DIV);
    localparam int unsigned HOLD_W = $clog2(HOLD_CYC + 1);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(DIV - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_HIGH,
        S_LOW,
        S_DONE,
        S_HOLD
    } state_t;

    state_t            state;
    logic [DIV_W-1:0]  div_cnt;
    logic [HOLD_W-1:0] hold_cnt;
    logic [2:0]        bit_cnt;
    logic [7:0]        tx_sh;
    logic [7:0]        rx_sh;
    logic              last_q;
    logic              rx_bit;

`ifdef SPI_LOOPBACK_EN
    logic unused_miso;
    assign unused_miso = miso_i;
    assign rx_bit      = mosi_o;
`else
    assign rx_bit      = miso_i;
`endif

    // Phase sequencer; every pin change happens on the edge that enters a phase.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state     <= S_IDLE;
            div_cnt   <= '0;
            hold_cnt  <= '0;
            bit_cnt   <= '0;
            tx_sh     <= '0;
            rx_sh     <= '0;
            last_q    <= 1'b0;
            data_rx_o <= '0;
            fin_o     <= 1'b0;
            busy_o    <= 1'b0;
            sclk_o    <= 1'b0;
            mosi_o    <= 1'b0;
            cs_o      <= 1'b1;
        end else begin
            fin_o <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (en_i) begin
                        tx_sh   <= data_tx_i;
                        bit_cnt <= 3'd7;
                        mosi_o  <= data_tx_i[7];
                        cs_o    <= 1'b0;
                        sclk_o  <= 1'b0;
                        busy_o  <= 1'b1;
                        div_cnt <= '0;
                        state   <= S_SETUP;
                    end
                end

                S_SETUP: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        sclk_o  <= 1'b1;
                        rx_sh   <= {rx_sh[6:0], rx_bit};
                        state   <= S_HIGH;
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end

                S_HIGH: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        sclk_o  <= 1'b0;
                        last_q  <= (bit_cnt == 3'd0);
                        if (bit_cnt != 3'd0) begin
                            tx_sh   <= {tx_sh[6:0], 1'b0};
                            mosi_o  <= tx_sh[6];
                            bit_cnt <= bit_cnt - 3'd1;
                        end
                        state <= S_LOW;
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end

                S_LOW: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        // last_q remembers whether the bit just finished was the final one
                        if (last_q) begin
                            cs_o      <= 1'b1;
                            mosi_o    <= 1'b0;
                            fin_o     <= 1'b1;
                            data_rx_o <= rx_sh;
                            state     <= S_DONE;
                        end else begin
                            sclk_o <= 1'b1;
                            rx_sh  <= {rx_sh[6:0], rx_bit};
                            state  <= S_HIGH;
                        end
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end

                S_DONE: begin
                    hold_cnt <= '0;
                    state    <= S_HOLD;
                end

                S_HOLD: begin
                    if (hold_cnt == HOLD_LAST) begin
                        hold_cnt <= '0;
                        busy_o   <= 1'b0;
                        state    <= S_IDLE;
                    end else begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_module_spi_master.sv
// Directed bench for module_spi_master: reset, single and back-to-back transfers,
// mid-transfer reset, and a DIV=2 instance exercising the loopback option.
module tb_module_spi_master;

    logic clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    logic       reset_i, en_i, en2, miso;
    logic [7:0] data_tx, data_tx2;
    logic [7:0] rx, rx2;
    logic       fin, busy, sclk, mosi, cs;
    logic       fin2, busy2, sclk2, mosi2, cs2;
    logic [7:0] slave_byte, slave_sh;
    logic [7:0] pat;
    logic       saw_fin;
    int         errors = 0;
    int         checks = 0;

    module_spi_master #(.DIV(5), .HOLD_CYC(4)) u_dut (
        .clk_i(clk_i), .reset_i(reset_i), .en_i(en_i), .data_tx_i(data_tx),
        .miso_i(miso), .data_rx_o(rx), .fin_o(fin), .busy_o(busy),
        .sclk_o(sclk), .mosi_o(mosi), .cs_o(cs)
    );

    module_spi_master #(.DIV(2), .HOLD_CYC(4)) u_dut2 (
        .clk_i(clk_i), .reset_i(reset_i), .en_i(en2), .data_tx_i(data_tx2),
        .miso_i(1'b0), .data_rx_o(rx2), .fin_o(fin2), .busy_o(busy2),
        .sclk_o(sclk2), .mosi_o(mosi2), .cs_o(cs2)
    );

    // Mode-0 slave: MSB presented when CS falls, next bit after each SCLK fall.
    always @(negedge cs) begin
        slave_sh = slave_byte;
        miso     = slave_sh[7];
    end
    always @(negedge sclk) begin
        if (cs === 1'b0) begin
            slave_sh = {slave_sh[6:0], 1'b0};
            miso     = slave_sh[7];
        end
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    initial begin
        reset_i = 1'b1; en_i = 1'b0; en2 = 1'b0; miso = 1'b0;
        data_tx = 8'h00; data_tx2 = 8'h00; slave_byte = 8'h00; slave_sh = 8'h00;
        saw_fin = 1'b0; pat = 8'h00;

        // Reset held 3 cycles while idle
        tick(3); reset_i = 1'b0; tick(4);
        reset_i = 1'b1; tick(3);
        check("rst_sclk", sclk, 0);
        check("rst_cs",   cs,   1);
        check("rst_mosi", mosi, 0);
        check("rst_rx",   rx,   8'h00);
        check("rst_fin",  fin,  0);
        check("rst_busy", busy, 0);
        reset_i = 1'b0; tick(2);

        // Single transfer 0xA5 out, slave returns 0x3C; j counts cycles after latch cycle s
        pat = 8'hA5; slave_byte = 8'h3C; data_tx = 8'hA5; en_i = 1'b1;
        for (int j = 1; j <= 91; j++) begin
            tick(1);
            if (j == 1) en_i = 1'b0;
            check($sformatf("t1_sclk@%0d", j), sclk,
                  (j >= 6 && j <= 85 && ((j - 6) % 10) < 5) ? 8'd1 : 8'd0);
            check($sformatf("t1_cs@%0d", j), cs, (j <= 85) ? 8'd0 : 8'd1);
            check($sformatf("t1_fin@%0d", j), fin, (j == 86) ? 8'd1 : 8'd0);
            check($sformatf("t1_busy@%0d", j), busy, (j <= 90) ? 8'd1 : 8'd0);
            if (j >= 6 && j <= 76 && ((j - 6) % 10) == 0)
                check($sformatf("t1_mosi@%0d", j), mosi, 8'(pat[7 - (j - 6) / 10]));
            if (j == 86) check("t1_rx", rx, 8'h3C);
        end
        tick(3);

        // Back-to-back with en_i held high: 0x11 then 0x22
        slave_byte = 8'h81; data_tx = 8'h11; en_i = 1'b1;
        tick(86);
        check("b2b_fin1", fin, 1);
        check("b2b_rx1",  rx,  8'h81);
        for (int j = 1; j <= 4; j++) begin
            tick(1);
            check($sformatf("hold_sclk@%0d", j), sclk, 0);
            check($sformatf("hold_cs@%0d", j),   cs,   1);
            check($sformatf("hold_fin@%0d", j),  fin,  0);
        end
        data_tx = 8'h22; slave_byte = 8'h7E;
        tick(1);
        check("b2b_idle_busy", busy, 0);
        check("b2b_idle_cs",   cs,   1);
        pat = 8'h22;
        for (int j = 1; j <= 86; j++) begin
            tick(1);
            if (j == 1) begin
                check("b2b_latch_cs",   cs,   0);
                check("b2b_latch_busy", busy, 1);
                check("b2b_latch_mosi", mosi, 0);
                en_i = 1'b0;
            end
            if (j >= 6 && j <= 76 && ((j - 6) % 10) == 0)
                check($sformatf("t2_mosi@%0d", j), mosi, 8'(pat[7 - (j - 6) / 10]));
            if (j == 86) begin
                check("b2b_fin2", fin, 1);
                check("b2b_rx2",  rx,  8'h7E);
            end
        end
        tick(6);

        // Reset asserted after the third rising edge
        slave_byte = 8'hFF; data_tx = 8'hFF; en_i = 1'b1;
        for (int j = 1; j <= 26; j++) begin
            tick(1);
            if (j == 1) en_i = 1'b0;
        end
        check("mid_sclk_high", sclk, 1);
        reset_i = 1'b1;
        tick(1);
        check("mid_sclk", sclk, 0);
        check("mid_cs",   cs,   1);
        check("mid_mosi", mosi, 0);
        check("mid_rx",   rx,   8'h00);
        check("mid_fin",  fin,  0);
        check("mid_busy", busy, 0);
        reset_i = 1'b0;
        for (int j = 0; j < 100; j++) begin
            tick(1);
            if (fin !== 1'b0) saw_fin = 1'b1;
        end
        check("mid_no_fin", saw_fin, 0);
        check("mid_rx_after", rx, 8'h00);
        check("mid_busy_after", busy, 0);

        // DIV=2 instance, 0xC3 with miso tied low
        data_tx2 = 8'hC3; en2 = 1'b1;
        for (int j = 1; j <= 36; j++) begin
            tick(1);
            if (j == 1) begin
                en2 = 1'b0;
                check("lb_cs", cs2, 0);
            end
            check($sformatf("lb_fin@%0d", j), fin2, (j == 35) ? 8'd1 : 8'd0);
            if (j == 35) begin
`ifdef SPI_LOOPBACK_EN
                check("lb_rx", rx2, 8'hC3);
`else
                check("lb_rx", rx2, 8'h00);
`endif
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/module_spi_master.md
# module_spi_master

Byte-wide SPI master shift engine, mode 0 (CPOL=0, CPHA=0), MSB first. It sits directly downstream of the SPI control FSM. It takes that FSM's `en_spi_o` and `data_tx_o` as `en_i` and `data_tx_i`. It returns `data_rx_o` and the one-cycle `fin_o` pulse as the FSM's `data_rx_i` and `spi_fin_i`. It drives the external `sclk_o`, `mosi_o` and `cs_o` pins and samples `miso_i`.

## Interface
Parameters:
- DIV, 5: system clocks per SCLK half-period; legal range ≥ 2 (10 MHz / (2·5) gives a 1 MHz SCLK).
- HOLD_CYC, 4: idle cycles enforced after `fin_o` before a new transfer may start; legal range ≥ 4.

Ports (the block uses one clock; reset is synchronous and active-high):
- clk_i  in  1  system clock, 10 MHz
- reset_i  in  1  synchronous, active-high reset
- en_i  in  1  transfer enable, level; sampled only in IDLE
- data_tx_i  in  8  byte to transmit; latched at transfer start
- miso_i  in  1  serial data from the slave
- data_rx_o  out  8  last received byte
- fin_o  out  1  one-cycle pulse when a transfer completes
- busy_o  out  1  high from the latch cycle through the end of HOLD
- sclk_o  out  1  serial clock, idles low
- mosi_o  out  1  serial data to the slave
- cs_o  out  1  chip select, active low

## Operation
- All outputs are registered. Reset values:
  - sclk_o=0, mosi_o=0, cs_o=1
  - data_rx_o=0x00, fin_o=0, busy_o=0
  - state=IDLE, all counters 0
- State machine:
  - IDLE: if en_i=1, latch data_tx_i into tx_sh, set bit_cnt=7, go to SETUP. Otherwise stay.
  - SETUP: cs_o=0, mosi_o=tx_sh[7], sclk_o=0. Stay DIV cycles, then go to HIGH.
  - HIGH: sclk_o=1. On the entry edge, shift miso_i into rx_sh LSB (rx_sh <= {rx_sh[6:0], miso_i}). Stay DIV cycles, then go to LOW.
  - LOW: sclk_o=0. On the entry edge, if bit_cnt≠0, shift tx_sh left, put the new tx_sh[7] on mosi_o and decrement bit_cnt. Stay DIV cycles. Then go to HIGH if the pre-decrement bit_cnt≠0, else go to DONE.
  - DONE (1 cycle): cs_o=1, mosi_o=0, fin_o=1, data_rx_o<=rx_sh. Go to HOLD.
  - HOLD: fin_o=0. Stay HOLD_CYC cycles, then go to IDLE; busy_o falls on entry to IDLE.
- Counters:
  - Divider counter is $clog2(DIV) bits and wraps to 0 on each phase change.
  - bit_cnt is 3 bits.
  - Hold counter is $clog2(HOLD_CYC+1) bits.
- data_rx_o holds its value until the next DONE.
- en_i is ignored outside IDLE. Dropping it mid-transfer does not abort the transfer.
- en_i held high continuously gives back-to-back transfers separated by DONE + HOLD. This spacing lets the control FSM load the next data_tx_i before the next latch.
- reset_i asserted in any state returns all outputs to their reset values on the next edge. No fin_o pulse is produced and any partial rx_sh is discarded.
- miso_i is used unsynchronised. Any pin synchroniser lives outside this block.

## Timing
- Start latch at cycle s (IDLE with en_i=1). From s+1:
  - cs_o=0 and MSB on mosi_o.
- SCLK edges:
  - First rising edge at s+1+DIV.
  - Rising edge of bit k (k=0..7) at s+1+DIV+2k·DIV.
  - Falling edge of bit k DIV cycles after its rising edge.
- Completion:
  - fin_o high and data_rx_o valid at s+1+17·DIV; for DIV=5 that is s+86.
  - cs_o rises in the same cycle as fin_o.
- Earliest next latch is fin cycle + HOLD_CYC + 1; for the default that is fin+5.
- mosi_o changes only while sclk_o=0 (setup or falling-edge cycle). MISO is captured on the rising-edge cycle.

## Configuration
- SPI_LOOPBACK_EN:
  - Defined: the shift-in source is mosi_o, internally looped, and miso_i is ignored. data_rx_o equals the transmitted byte.
  - Undefined: the shift-in source is miso_i.
- Pin outputs are identical in both builds.

## Test plan
- Reset: hold reset_i for 3 cycles mid-idle. Required: sclk_o=0, cs_o=1, mosi_o=0, data_rx_o=0x00, fin_o=0, busy_o=0.
- Single transfer, DIV=5: data_tx_i=0xA5 with the slave model returning 0x3C.
  - mosi_o sampled on the 8 rising edges reads 1,0,1,0,0,1,0,1.
  - fin_o pulses exactly at s+86 for one cycle, with data_rx_o=0x3C.
  - cs_o is low from s+1 through s+85.
- Back-to-back: en_i held high, with data_tx_i changed from 0x11 to 0x22 at fin+4.
  - Second latch occurs at fin+5.
  - Second transfer shifts out 0x22.
  - No SCLK edges occur during HOLD.
- Reset mid-transfer: assert reset_i after the 3rd rising edge.
  - Next cycle all outputs are at reset values.
  - No fin_o pulse.
  - data_rx_o stays at its prior value's reset, 0x00.
- Loopback build (SPI_LOOPBACK_EN), DIV=2: data_tx_i=0xC3 with miso_i tied to 0.
  - fin_o at s+35.
  - data_rx_o=0xC3.
